icache_dm: RTL and testbench

- Parametrised direct-mapped, read-only instruction cache with multi-word blocks. Replaces the single-cycle instruction pass-through between the datapath fetch port and the memory arbiter.
- Serves hits in the same cycle the request is presented. On a miss it runs a word-by-word block fill from memory.
- Sits inside the caches block: the datapath fetch port is on one side, the instruction channel of the memory interface is on the other.

---
 rtl/cpu_types_pkg.sv | 6 +
 rtl/icache_pkg.sv | 41 ++++
 rtl/icache_dm_if.sv | 29 ++
 rtl/icache_dm.sv | 128 ++++++++++++
 tb/tb_icache_dm.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU-wide scalar types.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

endpackage

// File: rtl/icache_pkg.sv
// Types and width helpers for the direct-mapped instruction cache.
package icache_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } icache_state_t;

  // Default geometry, also used to size the reference address-field struct.
  localparam int ICACHE_NSETS = 16;
  localparam int ICACHE_WPB   = 2;

  // Word-offset bits inside a block.
  function automatic int woff_w(input int wpb);
    return $clog2(wpb);
  endfunction

  // Set-index bits.
  function automatic int idx_w(input int nsets);
    return $clog2(nsets);
  endfunction

  // Tag bits: whatever is left of the 32-bit byte address.
  function automatic int tag_w(input int nsets, input int wpb);
    return 32 - 2 - woff_w(wpb) - idx_w(nsets);
  endfunction

  // Fill counter bits; a one-word block still needs a 1-bit counter.
  function automatic int cnt_w(input int wpb);
    return (woff_w(wpb) == 0) ? 1 : woff_w(wpb);
  endfunction

  // Address split for the default geometry, MSB first.
  typedef struct packed {
    logic [tag_w(ICACHE_NSETS, ICACHE_WPB)-1:0] tag;
    logic [idx_w(ICACHE_NSETS)-1:0]             idx;
    logic [woff_w(ICACHE_WPB)-1:0]              woff;
    logic [1:0]                                 bytoff;
  } icachef_t;

endpackage

// File: rtl/icache_dm_if.sv
// Fetch-port and instruction memory-channel signals of the instruction cache.
// slave: the cache. master: the datapath fetch port plus the memory arbiter.
interface icache_dm_if;
  import cpu_types_pkg::*;

  // datapath fetch side
  logic  imemREN;
  word_t imemaddr;
  logic  inval;
  logic  ihit;
  word_t imemload;

  // memory instruction channel
  logic  iREN;
  word_t iaddr;
  word_t iload;
  logic  iwait;

  modport slave (
    input  imemREN, imemaddr, inval, iload, iwait,
    output ihit, imemload, iREN, iaddr
  );

  modport master (
    output imemREN, imemaddr, inval, iload, iwait,
    input  ihit, imemload, iREN, iaddr
  );

endinterface

// File: rtl/icache_dm.sv
// Direct-mapped, read-only instruction cache with multi-word blocks.
// Hits are combinational; a miss fills the whole block word by word.
module icache_dm
  import cpu_types_pkg::*;
  import icache_pkg::*;
#(
  parameter int NSETS           = ICACHE_NSETS,
  parameter int WORDS_PER_BLOCK = ICACHE_WPB
) (
  input  logic         CLK,
  input  logic         nRST,
  icache_dm_if.slave   cif
);

  localparam int WOFF = woff_w(WORDS_PER_BLOCK);
  localparam int IDX  = idx_w(NSETS);
  localparam int TAGW = tag_w(NSETS, WORDS_PER_BLOCK);
  localparam int CNTW = cnt_w(WORDS_PER_BLOCK);

  localparam logic [CNTW-1:0] LAST_WORD = CNTW'(WORDS_PER_BLOCK - 1);
  localparam logic [CNTW-1:0] WORD_MASK = CNTW'(WORDS_PER_BLOCK - 1);
  localparam word_t           BLK_MASK  = word_t'(WORDS_PER_BLOCK * 4 - 1);

  localparam logic [0:0] ST_IDLE = IDLE;
  localparam logic [0:0] ST_FILL = FILL;

  // controller state
  logic [0:0]      state;
  logic [CNTW-1:0] cnt;
  word_t           miss_addr;

  // storage
  logic [NSETS-1:0] valid;
  logic [TAGW-1:0]  tag_arr  [NSETS];
  word_t            data_arr [NSETS][WORDS_PER_BLOCK];

  // request and fill address fields
  logic [IDX-1:0]  req_idx;
  logic [TAGW-1:0] req_tag;
  logic [CNTW-1:0] req_word;
  logic [IDX-1:0]  fill_idx;
  logic [TAGW-1:0] fill_tag;

  logic lookup_hit;
  logic hit;
  logic miss_start;
  logic word_acc;

  assign req_idx  = IDX'(cif.imemaddr >> (2 + WOFF));
  assign req_tag  = TAGW'(cif.imemaddr >> (2 + WOFF + IDX));
  assign req_word = CNTW'(cif.imemaddr >> 2) & WORD_MASK;
  assign fill_idx = IDX'(miss_addr >> (2 + WOFF));
  assign fill_tag = TAGW'(miss_addr >> (2 + WOFF + IDX));

  assign lookup_hit = valid[req_idx] && (tag_arr[req_idx] == req_tag);

  // inval suppresses both a hit and a new miss in the same cycle.
  assign hit        = nRST && (state == ST_IDLE) && cif.imemREN && lookup_hit && !cif.inval;
  assign miss_start = (state == ST_IDLE) && cif.imemREN && !lookup_hit && !cif.inval;
  assign word_acc   = (state == ST_FILL) && !cif.iwait && !cif.inval;

  // Drive the fetch and memory outputs from the current state.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned, which would infer a latch.
    cif.ihit     = 1'b0;
    cif.imemload = '0;
    cif.iREN     = 1'b0;
    cif.iaddr    = '0;
    if (hit) begin
      cif.ihit     = 1'b1;
      cif.imemload = data_arr[req_idx][req_word];
    end
    if (nRST && (state == ST_FILL)) begin
      cif.iREN  = 1'b1;
      cif.iaddr = miss_addr | (word_t'(cnt) << 2);
    end
  end

  // Control state, fill counter and valid bits; reset and inval win over everything.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!nRST) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      miss_addr <= '0;
      valid     <= '0;
    end else if (cif.inval) begin
      valid <= '0;
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (miss_start) begin
            miss_addr      <= cif.imemaddr & ~BLK_MASK;
            cnt            <= '0;
            valid[req_idx] <= 1'b0;
            state          <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (!cif.iwait) begin
            if (cnt == LAST_WORD) begin
              valid[fill_idx] <= 1'b1;
              cnt             <= '0;
              state           <= ST_IDLE;
            end else begin
              cnt <= cnt + CNTW'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Write accepted fill words and, with the last one, the tag.
  always_ff @(posedge CLK) begin
    // NOTE: data and tag arrays are deliberately not reset; the reset valid bits keep stale contents unreachable.
    if (nRST && word_acc) begin
      data_arr[fill_idx][cnt] <= cif.iload;
      if (cnt == LAST_WORD) begin
        tag_arr[fill_idx] <= fill_tag;
      end
    end
  end

endmodule

// File: tb/tb_icache_dm.sv
// Self-checking bench for icache_dm: directed test-plan scenarios followed by
// random fetches, checked against a block-level reference model and a scoreboard.
module tb_icache_dm;
  import cpu_types_pkg::*;

  localparam int NS  = 16;
  localparam int WPB = 2;

  logic CLK;
  logic nRST;

  icache_dm_if intf ();

  icache_dm #(
    .NSETS           (NS),
    .WORDS_PER_BLOCK (WPB)
  ) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .cif  (intf)
  );

  int    checks  = 0;
  int    errors  = 0;
  int    cyc     = 0;
  int    mem_lat = 2;      // fixed wait cycles per word, or -1 for random
  int    cached [NS];      // block number held by each set, -1 if none
  word_t exp_q  [$];       // expected imemload per request
  word_t addr_q [$];       // expected iaddr per accepted memory word

  task automatic check(input string name, input word_t act, input word_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic word_t mem_word(input word_t a);
    if (a == 32'h40) return 32'hAAAA0001;
    if (a == 32'h44) return 32'hAAAA0002;
    return {a[15:0] ^ 16'hC0DE, a[15:0] + 16'h1};
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic model_inval();
    for (int i = 0; i < NS; i++) cached[i] = -1;
  endtask

  task automatic flush_queues();
    exp_q.delete();
    addr_q.delete();
  endtask

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  // Memory model: answers the current iaddr after a configurable wait.
  initial begin
    int lat_left;
    lat_left   = -1;
    intf.iwait = 1'b1;
    intf.iload = '0;
    forever begin
      @(posedge CLK);
      #2;
      if (!intf.iREN) begin
        intf.iwait = 1'b1;
        lat_left   = -1;
      end else begin
        if (lat_left < 0) lat_left = (mem_lat < 0) ? int'($urandom_range(0, 3)) : mem_lat;
        if (lat_left == 0) begin
          intf.iwait = 1'b0;
          intf.iload = mem_word(intf.iaddr);
          lat_left   = -1;
        end else begin
          intf.iwait = 1'b1;
          lat_left--;
        end
      end
    end
  end

  // Monitor: scoreboards fetched data and fill addresses.
  initial forever begin
    @(negedge CLK);
    if (nRST) begin
      if (intf.ihit) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_hit: got ihit=1 addr=%h expected no hit (cycle %0d)", intf.imemaddr, cyc);
        end else begin
          check("imemload", intf.imemload, exp_q.pop_front());
        end
      end else begin
        check("imemload_nohit", intf.imemload, '0);
      end
      if (intf.iREN && !intf.iwait && !intf.inval) begin
        if (addr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_fill: got iaddr=%h expected no fill (cycle %0d)", intf.iaddr, cyc);
        end else begin
          check("iaddr", intf.iaddr, addr_q.pop_front());
        end
      end
    end
  end

  // Full fetch: hit in the same cycle or miss, fill, and hit one cycle after the last word.
  task automatic fetch(input word_t a);
    int b;
    int s;
    int last_acc;
    bit got;
    b        = int'(a >> 3);
    s        = b % NS;
    last_acc = -1;
    got      = 1'b0;
    step();
    intf.imemREN  = 1'b1;
    intf.imemaddr = a;
    exp_q.push_back(mem_word(a & ~word_t'(3)));
    if (cached[s] == b) begin
      @(negedge CLK);
      check("hit_ihit", word_t'(intf.ihit), 1);
      check("hit_iren", word_t'(intf.iREN), 0);
    end else begin
      for (int w = 0; w < WPB; w++) addr_q.push_back(word_t'(b * WPB * 4 + w * 4));
      cached[s] = -1;
      @(negedge CLK);
      check("miss_ihit", word_t'(intf.ihit), 0);
      for (int i = 0; i < 200 && !got; i++) begin
        @(negedge CLK);
        if (intf.ihit) got = 1'b1;
        else if (intf.iREN && !intf.iwait) last_acc = cyc;
      end
      check("miss_done", word_t'(got), 1);
      if (got) begin
        check("miss_penalty", word_t'(cyc), word_t'(last_acc + 1));
        cached[s] = b;
      end else begin
        flush_queues();
      end
    end
    step();
    intf.imemREN = 1'b0;
  endtask

  // Start a miss and return at the negedge just before the first word is accepted.
  task automatic start_fill(input word_t a);
    int b;
    bit got;
    b   = int'(a >> 3);
    got = 1'b0;
    step();
    intf.imemREN  = 1'b1;
    intf.imemaddr = a;
    exp_q.push_back(mem_word(a & ~word_t'(3)));
    for (int w = 0; w < WPB; w++) addr_q.push_back(word_t'(b * WPB * 4 + w * 4));
    cached[b % NS] = -1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge CLK);
      if (intf.iREN && !intf.iwait) got = 1'b1;
    end
    check("first_word_seen", word_t'(got), 1);
  endtask

  task automatic inval_idle();
    step();
    intf.inval = 1'b1;
    step();
    intf.inval = 1'b0;
    model_inval();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit done;
    model_inval();
    nRST          = 1'b0;
    intf.imemREN  = 1'b1;
    intf.imemaddr = 32'h40;
    intf.inval    = 1'b0;

    // reset state
    repeat (3) step();
    @(negedge CLK);
    check("rst_ihit", word_t'(intf.ihit), 0);
    check("rst_imemload", intf.imemload, 0);
    check("rst_iren", word_t'(intf.iREN), 0);
    check("rst_iaddr", intf.iaddr, 0);
    step();
    intf.imemREN = 1'b0;
    nRST         = 1'b1;
    @(negedge CLK);
    check("post_rst_iren", word_t'(intf.iREN), 0);
    check("post_rst_iaddr", intf.iaddr, 0);

    // 1: cold miss, 2 wait cycles per word; 2: spatial hit
    mem_lat = 2;
    fetch(32'h40);
    fetch(32'h44);

    // 3: conflict eviction and refill
    fetch(32'hC0);
    fetch(32'h40);

    // 4: inval after the first word of a fill
    fetch(32'hC0);
    start_fill(32'h40);
    step();
    intf.inval   = 1'b1;
    intf.imemREN = 1'b0;
    step();
    intf.inval = 1'b0;
    @(negedge CLK);
    check("inval_iren", word_t'(intf.iREN), 0);
    check("inval_ihit", word_t'(intf.ihit), 0);
    flush_queues();
    model_inval();
    fetch(32'h40);
    fetch(32'h44);

    // 5: reset during a fill; the cached 0x44 block is lost
    start_fill(32'h80);
    step();
    nRST         = 1'b0;
    intf.imemREN = 1'b0;
    step();
    nRST = 1'b1;
    @(negedge CLK);
    check("rstfill_iren", word_t'(intf.iREN), 0);
    check("rstfill_ihit", word_t'(intf.ihit), 0);
    check("rstfill_iaddr", intf.iaddr, 0);
    flush_queues();
    model_inval();
    fetch(32'h44);

    // 6: request dropped after the first word; the fill still completes
    inval_idle();
    start_fill(32'h40);
    step();
    intf.imemREN  = 1'b0;
    intf.imemaddr = $urandom;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge CLK);
      check("drop_ihit", word_t'(intf.ihit), 0);
      if (!intf.iREN) done = 1'b1;
    end
    check("drop_fill_done", word_t'(done), 1);
    check("drop_words_left", word_t'(addr_q.size()), 0);
    cached[8] = 8;
    step();
    intf.imemREN  = 1'b1;
    intf.imemaddr = 32'h40;
    @(negedge CLK);
    check("drop_rehit", word_t'(intf.ihit), 1);
    step();
    intf.imemREN = 1'b0;

    // random fetches over a small address pool with random memory latency
    mem_lat = -1;
    repeat (120) begin
      if ($urandom_range(0, 11) == 0) inval_idle();
      else fetch(word_t'($urandom_range(0, 127)) << 2);
    end

    repeat (3) step();
    check("exp_q_empty", word_t'(exp_q.size()), 0);
    check("addr_q_empty", word_t'(addr_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
